add9_acc: RTL
=============

Name: add9_acc

Overview:
- Sequential 9-bit signed saturating accumulator; the additive counterpart to the 9-bit subtractor (D = A - B).
- Integrates the speed-error samples produced by the subtractor into a running sum for the BLDC PI loop's integral term.
- Also dumps a windowed sum every WINDOW samples, for duty-cycle update.
- Valid/ready-free: the producer asserts in_valid for one cycle per sample, and the block accepts every valid sample.

Parameters:
- WIDTH, 9, data width of samples and of the accumulator (two's complement).
- ACC_MAX, 255, upper saturation limit (signed; must be ≤ 2^(WIDTH-1)-1).
- ACC_MIN, -256, lower saturation limit (signed; must be ≥ -2^(WIDTH-1)).
- WINDOW, 16, number of samples per dump window (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of accumulator, window count and sticky flag.
- in_valid  input  1  sample strobe, one sample per high cycle.
- in_d  input  WIDTH  signed error sample (subtractor D output).
- acc  output  WIDTH  running saturated sum, registered.
- out_valid  output  1  one-cycle pulse when acc updated from a sample.
- win_sum  output  WIDTH  sum latched at end of each window.
- win_valid  output  1  one-cycle pulse when win_sum updated.
- sat_flag  output  1  sticky: set when any addition saturated.
- cnt  output  8  samples accumulated in the current window.

Behaviour:
- Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: acc=0, out_valid=0, win_sum=0, win_valid=0, sat_flag=0, cnt=0, state=IDLE.
- Arithmetic:
  - sum = sext(acc, WIDTH+1) + sext(in_d, WIDTH+1).
  - If sum > ACC_MAX, the result is ACC_MAX. If sum < ACC_MIN, the result is ACC_MIN. Otherwise the result is sum[WIDTH-1:0].
  - Clamping also sets sat_flag.
  - Compare as signed WIDTH+1 values; no wrap-around ever reaches acc.
- Latency: a sample with in_valid high in cycle N is reflected in acc, with out_valid=1, in cycle N+1. Throughput is one sample per cycle.
- FSM:
  - IDLE: acc holds 0, cnt=0. in_valid → perform the first add (0 + in_d, saturated), cnt=1, go to RUN.
  - RUN: each in_valid adds and increments cnt. When the incoming sample makes cnt reach WINDOW:
    - win_sum ← new saturated acc, pulse win_valid;
    - acc ← 0, cnt ← 0, go to IDLE.
    - out_valid still pulses, and acc shows 0 that cycle. win_sum carries the window total.
  - No in_valid → all state holds; out_valid=0, win_valid=0.
- Clear:
  - clr with no in_valid: acc=0, cnt=0, sat_flag=0, state=IDLE, no pulses.
  - clr and in_valid in the same cycle: clear first, then the sample is taken as the first of a new window: acc=sat(in_d), cnt=1, state=RUN, out_valid=1. sat_flag reflects only this add.
- Priority: rst > clr > in_valid.
- Reset mid-window: all state drops to reset values; the partial window is discarded with no win_valid.
- sat_flag is cleared only by rst or clr and is not cleared at window end.
- Saturation persists: once clamped at ACC_MAX, further positive samples keep acc at ACC_MAX and keep setting the flag. A negative sample moves acc down normally.

Decomposition:
- Shared package bldc_pkg holds:
  - the WIDTH default (9);
  - ACC_MAX/ACC_MIN defaults;
  - FSM state encoding (IDLE=1'b0, RUN=1'b1).
- One natural sub-module: sat_add, combinational (a, b, min, max → y, sat). Reusable by the PI proportional path.
- Window counter and FSM stay in the top module.

Test Plan:
- rst held 2 cycles then released → all outputs 0, no pulses for 10 idle cycles.
- Samples +5, -9, +3 on consecutive cycles → acc 5, -4, -1 in the cycles after each; out_valid high 3 cycles; sat_flag=0; cnt 1, 2, 3.
- Samples +200, +100 → acc 200, then 255; sat_flag=1. Then -300-equivalent samples -256, -256 → acc -1, then -256; sat_flag stays 1.
- WINDOW=16, sixteen samples of +2 → win_valid pulses with win_sum=32 on the 16th sample's update cycle; acc=0, cnt=0 that cycle. The next sample +7 gives acc=7, cnt=1.
- After acc=40, cnt=5: assert clr and in_valid with in_d=-3 in one cycle → acc=-3, cnt=1, sat_flag=0, out_valid=1, no win_valid.
- Mid-window (cnt=10, acc=50): assert rst for 1 cycle → acc=0, cnt=0, win_sum unchanged at its reset value 0, no win_valid. The next sample +1 gives acc=1.

Source files
------------

// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared BLDC datapath defaults and accumulator state encoding
package bldc_pkg;

    localparam int DATA_WIDTH  = 9;
    localparam int ACC_MAX_DEF = 255;
    localparam int ACC_MIN_DEF = -256;
    localparam int WINDOW_DEF  = 16;
    localparam int CNT_WIDTH   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_e;

    // Sign-extend a WIDTH-bit two's complement value by one bit.
    function automatic logic [DATA_WIDTH:0] sext1(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed add with clamping to [min, max]
module sat_add
    import bldc_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] y,
    output logic             sat
);

    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] lo;
    logic signed [WIDTH:0] hi;

    // One extra bit holds the exact sum, so clamping never sees a wrapped value.
    always_comb begin
        sum = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        lo  = $signed({min[WIDTH-1], min});
        hi  = $signed({max[WIDTH-1], max});
        y   = sum[WIDTH-1:0];
        sat = 1'b0;
        if (sum > hi) begin
            y   = max;
            sat = 1'b1;
        end else if (sum < lo) begin
            y   = min;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/add9_acc.sv
// rtl/add9_acc.sv - windowed signed saturating accumulator for the PI integral term
module add9_acc
    import bldc_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int ACC_MAX = ACC_MAX_DEF,
    parameter int ACC_MIN = ACC_MIN_DEF,
    parameter int WINDOW  = WINDOW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_d,
    output logic [WIDTH-1:0]     acc,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     win_sum,
    output logic                 win_valid,
    output logic                 sat_flag,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0]     MAX_V    = WIDTH'(ACC_MAX);
    localparam logic [WIDTH-1:0]     MIN_V    = WIDTH'(ACC_MIN);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(WINDOW);

    acc_state_e           state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     win_sum_q, win_sum_d;
    logic                 out_valid_q, out_valid_d;
    logic                 win_valid_q, win_valid_d;
    logic                 sat_q, sat_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 fresh;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_y;
    logic                 add_sat;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // A clear in the same cycle as a sample makes that sample start a new window.
    assign fresh   = clr || (state_q == IDLE);
    assign add_a   = fresh ? '0 : acc_q;
    assign cnt_inc = fresh ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);

    sat_add #(
        .WIDTH (WIDTH)
    ) u_sat_add (
        .a   (add_a),
        .b   (in_d),
        .min (MIN_V),
        .max (MAX_V),
        .y   (add_y),
        .sat (add_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        win_sum_d   = win_sum_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        win_valid_d = 1'b0;

        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end

        if (in_valid) begin
            out_valid_d = 1'b1;
            sat_d       = sat_d | add_sat;
            if (cnt_inc == WIN_LAST) begin
                win_sum_d   = add_y;
                win_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = IDLE;
            end else begin
                acc_d   = add_y;
                cnt_d   = cnt_inc;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            win_sum_q   <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            win_sum_q   <= win_sum_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign acc       = acc_q;
    assign out_valid = out_valid_q;
    assign win_sum   = win_sum_q;
    assign win_valid = win_valid_q;
    assign sat_flag  = sat_q;
    assign cnt       = cnt_q;

endmodule
